// File: rtl/requant_pipe.sv
// requant_pipe: multi-lane accumulator requantiser.
// Stage 1 rounds half-up and arithmetically shifts each lane in IN_W+1 bits.
// Stage 2 clamps each lane to the signed or ReLU output range.
// out_data is registered, and a saturating counter tracks clamped lanes.
module requant_pipe #(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 8,
  parameter int LANES   = 4,
  parameter int SHIFT_W = 5
) (
  input  logic                     clk,
  input  logic                     srstn,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic                     cfg_relu,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*IN_W-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_data,
  input  logic                     sat_clr,
  output logic [15:0]              sat_cnt
);

  localparam int CNT_W = $clog2(LANES + 1);

  // Rounds half-up, then shifts right arithmetically. The extra headroom bit
  // keeps a large positive sum from wrapping negative when the bias is added.
  function automatic logic signed [IN_W:0] round_shift(
    input logic signed [IN_W-1:0] x,
    input logic [SHIFT_W-1:0]     sh
  );
    logic signed [IN_W:0] xe;
    logic signed [IN_W:0] bias;
    logic signed [IN_W:0] r;
    xe   = {x[IN_W-1], x};
    bias = '0;
    if (sh != '0)
      bias = {{IN_W{1'b0}}, 1'b1} <<< (sh - 1'b1);
    r = xe + bias;
    return r >>> sh;
  endfunction

  // Clamps to [lo, hi] and returns {sat_flag, value}.
  function automatic logic [OUT_W:0] clamp(
    input logic signed [IN_W:0] s,
    input logic                 relu
  );
    logic signed [IN_W:0] hi;
    logic signed [IN_W:0] lo;
    hi = '0;
    hi[OUT_W-2:0] = '1;
    lo = relu ? '0 : ~hi;
    if (s > hi)
      return {1'b1, hi[OUT_W-1:0]};
    else if (s < lo)
      return {1'b1, lo[OUT_W-1:0]};
    else
      return {1'b0, s[OUT_W-1:0]};
  endfunction

  // Adds a per-beat lane count and sticks at the counter's maximum.
  function automatic logic [15:0] sat_add(
    input logic [15:0]      cnt,
    input logic [CNT_W-1:0] inc
  );
    logic [16:0] sum;
    sum = {1'b0, cnt} + 17'(inc);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic                      vld_p1;
  logic                      vld_p2;
  logic                      relu_p1;
  logic signed [IN_W:0]      shv_p0 [LANES];
  logic signed [IN_W:0]      shv_p1 [LANES];
  logic [LANES*OUT_W-1:0]    clamp_data;
  logic [CNT_W-1:0]          nsat_nx;
  logic [CNT_W-1:0]          nsat_p2;
  logic [OUT_W:0]            c;
  logic                      s1_adv;
  logic                      s2_adv;
  logic                      in_fire;
  logic                      out_fire;

  assign s2_adv    = ~vld_p2 | out_ready;
  assign s1_adv    = ~vld_p1 | s2_adv;
  assign in_ready  = s1_adv;
  assign in_fire   = in_valid & s1_adv;
  assign out_valid = vld_p2;
  assign out_fire  = vld_p2 & out_ready;

  // Stage 0 -> 1 datapath: round and shift every lane of the incoming beat.
  always_comb begin
    for (int i = 0; i < LANES; i++)
      shv_p0[i] = round_shift($signed(in_data[i*IN_W +: IN_W]), cfg_shift);
  end

  // Stage 1 -> 2 datapath: clamp each shifted lane and count clamped lanes.
  always_comb begin
    clamp_data = '0;
    nsat_nx    = '0;
    c          = '0;
    for (int i = 0; i < LANES; i++) begin
      c = clamp(shv_p1[i], relu_p1);
      clamp_data[i*OUT_W +: OUT_W] = c[OUT_W-1:0];
      nsat_nx = nsat_nx + CNT_W'(c[OUT_W]);
    end
  end

  // Stage valid flags advance under the ready chain; reset empties the pipe.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (s1_adv) vld_p1 <= in_valid;
      if (s2_adv) vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1 boundary: shifted lanes and ReLU mode captured with the beat ----
  always_ff @(posedge clk) begin
    if (in_fire) begin
      shv_p1  <= shv_p0;
      relu_p1 <= cfg_relu;
    end
  end

  // ---- stage 2 boundary: clamped output beat and its saturated-lane count ----
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      out_data <= '0;
      nsat_p2  <= '0;
    end else if (s2_adv && vld_p1) begin
      out_data <= clamp_data;
      nsat_p2  <= nsat_nx;
    end
  end

  // Saturation counter: counts once per fired beat, clear wins over increment.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn)
      sat_cnt <= '0;
    else if (sat_clr)
      sat_cnt <= '0;
    else if (out_fire)
      sat_cnt <= sat_add(sat_cnt, nsat_p2);
  end

endmodule

// File: tb/tb_requant_pipe.sv
// tb_requant_pipe: directed scoreboard bench for requant_pipe.
module tb_requant_pipe;

  localparam int IN_W    = 32;
  localparam int OUT_W   = 8;
  localparam int LANES   = 4;
  localparam int SHIFT_W = 5;

  logic                    clk = 1'b0;
  logic                    srstn;
  logic [SHIFT_W-1:0]      cfg_shift;
  logic                    cfg_relu;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*IN_W-1:0]   in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*OUT_W-1:0]  out_data;
  logic                    sat_clr;
  logic [15:0]             sat_cnt;

  always #5 clk = ~clk;

  requant_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .srstn(srstn), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_clr(sat_clr), .sat_cnt(sat_cnt)
  );

  typedef struct {
    logic [LANES*OUT_W-1:0] data;
    int                     nsat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_sat = 0;
  logic prev_stall = 1'b0;
  logic [LANES*OUT_W-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference requantiser in 64-bit integer arithmetic.
  function automatic void model(input logic [LANES*IN_W-1:0] din, input int sh, input bit relu,
                                output logic [LANES*OUT_W-1:0] dout, output int nsat);
    longint x, r, s, hi, lo;
    hi = (64'sd1 <<< (OUT_W-1)) - 1;
    lo = relu ? 64'sd0 : -hi - 1;
    nsat = 0;
    dout = '0;
    for (int i = 0; i < LANES; i++) begin
      x = $signed(din[i*IN_W +: IN_W]);
      r = x + ((sh == 0) ? 64'sd0 : (64'sd1 <<< (sh - 1)));
      s = r >>> sh;
      if (s > hi) begin s = hi; nsat++; end
      else if (s < lo) begin s = lo; nsat++; end
      dout[i*OUT_W +: OUT_W] = s[OUT_W-1:0];
    end
  endfunction

  task automatic send(input int a, input int b, input int c, input int d,
                      input int sh, input bit relu);
    logic [LANES*IN_W-1:0] din;
    exp_t e;
    int   lanes [4];
    bit   fired;
    lanes = '{a, b, c, d};
    for (int i = 0; i < LANES; i++) din[i*IN_W +: IN_W] = lanes[i];
    model(din, sh, relu, e.data, e.nsat);
    in_data   = din;
    cfg_shift = sh[SHIFT_W-1:0];
    cfg_relu  = relu;
    in_valid  = 1'b1;
    fired     = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk); #1;
      if (in_ready) begin
        q.push_back(e);
        fired = 1'b1;
        break;
      end
    end
    if (!fired) check("in_fire_timeout", fired, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_empty", q.size(), 0);
  endtask

  // Output monitor: counter, ready, hold-stability and scoreboard checks.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   n;
    if (!srstn) begin
      exp_sat    = 0;
      prev_stall = 1'b0;
    end else begin
      n = 0;
      check("sat_cnt", sat_cnt, exp_sat[15:0]);
      check("in_ready", in_ready, !(q.size() >= 2 && !out_ready));
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_beat", out_valid, 0);
        else begin
          e = q.pop_front();
          check("out_data", out_data, e.data);
          n = e.nsat;
        end
      end
      if (sat_clr) exp_sat = 0;
      else if (out_valid && out_ready) exp_sat = (exp_sat + n > 65535) ? 65535 : exp_sat + n;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int pat [6];
    pat       = '{1, 0, 0, 1, 0, 1};
    srstn     = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    in_valid  = 1'b0;
    cfg_shift = '0;
    cfg_relu  = 1'b0;
    in_data   = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    repeat (2) @(posedge clk);
    #2 srstn = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // ReLU clamp, latency of two edges
    send(100, 31, -50, 10000, 6, 1);
    check("t1_lat_edge1", out_valid, 0);
    @(posedge clk); #1;
    check("t1_lat_edge2", out_valid, 1);
    check("t1_data", out_data, {8'd127, 8'd0, 8'd0, 8'd2});
    @(posedge clk); #1;
    check("t1_sat_cnt", sat_cnt, 2);

    // signed clamp with rounding on negative values
    send(-4096, -4112, 4063, 16, 5, 0);
    @(posedge clk); #1;
    check("t2_data", out_data, {8'd1, 8'd127, 8'h80, 8'h80});
    drain();

    // zero shift and large positive sum
    send(5, -7, 200, -129, 0, 0);
    send(32'h7fffffff, -1, 0, 0, 6, 0);
    @(posedge clk); #1;
    check("t3_no_wrap", out_data[7:0], 8'd127);
    drain();

    // back-pressure burst
    fork
      begin
        for (int n = 0; n < 6; n++)
          send($urandom, $urandom, $urandom, $urandom, $urandom_range(0, 31), 1'($urandom_range(0, 1)));
      end
      begin
        for (int k = 0; k < 30; k++) begin
          out_ready = pat[k % 6][0];
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // counter preset to 0xFFFE, then sticky saturation
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    for (int n = 0; n < 16383; n++) send(1000, -1000, 1000, -1000, 0, 0);
    send(1000, -1000, 0, 0, 0, 0);
    drain();
    @(posedge clk); #1;
    check("t5_preset", sat_cnt, 16'hFFFE);
    send(1000, 1000, -1000, -1000, 0, 0);
    drain();
    @(posedge clk); #1;
    check("t5_sticky", sat_cnt, 16'hFFFF);
    send(1000, 1000, 1000, 1000, 0, 0);
    @(posedge clk); #1;
    check("t5_clr_valid", out_valid, 1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check("t5_clr_prio", sat_cnt, 0);
    drain();

    // asynchronous reset with two beats in flight
    out_ready = 1'b0;
    send(300, -300, 3, 4, 2, 0);
    send(-5, 6, 70, 8000, 3, 1);
    #1 srstn = 1'b0;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_data", out_data, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #2 srstn = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t6_no_ghost", out_valid, 0);
    send(7, 8, 9, 10, 1, 0);
    check("t6_lat_edge1", out_valid, 0);
    @(posedge clk); #1;
    check("t6_lat_edge2", out_valid, 1);
    check("t6_data", out_data, {8'd5, 8'd5, 8'd4, 8'd4});
    drain();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
